// File: rtl/stream_downsize.sv
// ---------------------------------------------------------------------------
// stream_downsize
//
// Wide-to-narrow stream width converter. A wide word of RATIO lanes is taken
// on the input valid/ready handshake. Its lanes are then emitted one per
// narrow handshake, starting with lane 0 (the LSBs).
//
// Only the first `cnt` lanes of a word are emitted. An input count of 0, or
// one above RATIO, means a full word. The word's last flag is attached to its
// final emitted lane.
//
// The final lane of a word can be handed off in the same cycle that the next
// wide word is accepted. This gives one narrow lane per cycle with no bubble
// between words. The price is a combinational path from out_ready to
// in_ready.
// ---------------------------------------------------------------------------
module stream_downsize #(
   parameter int WIDTH = 8,
   parameter int RATIO = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH*RATIO-1:0]   in_data,
   input  logic [$clog2(RATIO+1)-1:0] in_cnt,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_last
);

   localparam int DW = WIDTH * RATIO;
   localparam int CW = $clog2(RATIO + 1);
   localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------

   // Out-of-range counts (0 or above RATIO) collapse to a full word.
   function automatic logic [CW-1:0] eff_cnt(input logic [CW-1:0] c);
      logic [CW-1:0] r;
      if ((c == {CW{1'b0}}) || (c > CW'(RATIO))) begin
         r = CW'(RATIO);
      end else begin
         r = c;
      end
      return r;
   endfunction

   // Select lane i of a wide word.
   function automatic logic [WIDTH-1:0] lane_of(input logic [DW-1:0] w,
                                                 input logic [IW-1:0] i);
      return w[int'(i)*WIDTH +: WIDTH];
   endfunction

   // ------------------------------------------------------------------
   // State and holding register
   // ------------------------------------------------------------------
   state_t             state_r;
   state_t             state_nxt_s;
   logic [DW-1:0]      data_r;
   logic [CW-1:0]      cnt_r;
   logic               last_r;
   logic [IW-1:0]      idx_r;
   logic [WIDTH-1:0]   out_data_r;
   logic               out_last_r;

   // ------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------
   logic [CW-1:0]      in_cnt_eff_s;
   logic [IW-1:0]      last_idx_s;
   logic [IW-1:0]      idx_inc_s;
   logic               busy_s;
   logic               final_s;
   logic               in_ready_s;
   logic               in_hs_s;
   logic               out_hs_s;
   logic               adv_s;
   logic               drain_s;

   // Handshake and lane-position decode shared by the FSM and the datapath.
   always_comb begin
      in_cnt_eff_s = eff_cnt(in_cnt);
      last_idx_s   = IW'(cnt_r - CW'(1));
      idx_inc_s    = idx_r + IW'(1);
      busy_s       = (state_r == BUSY);
      final_s      = busy_s && (idx_r == last_idx_s);
      // The final lane frees the holding register in the cycle it is taken.
      in_ready_s   = !busy_s || (final_s && out_ready);
      in_hs_s      = in_valid && in_ready_s;
      out_hs_s     = busy_s && out_ready;
      // Step to the next lane of the same word.
      adv_s        = out_hs_s && !final_s;
      // The final lane leaves and nothing replaces it.
      drain_s      = out_hs_s && final_s && !in_valid;
   end

   // Next-state logic for the IDLE/BUSY controller.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_hs_s) begin
               state_nxt_s = BUSY;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY: begin
            if (drain_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = BUSY;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register; reset discards any word in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Holding register, lane index and the registered output lane.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_r     <= {DW{1'b0}};
         cnt_r      <= CW'(RATIO);
         last_r     <= 1'b0;
         idx_r      <= {IW{1'b0}};
         out_data_r <= {WIDTH{1'b0}};
         out_last_r <= 1'b0;
      end else if (in_hs_s) begin
         // New word, from IDLE or overlapped with the previous final lane.
         data_r     <= in_data;
         cnt_r      <= in_cnt_eff_s;
         last_r     <= in_last;
         idx_r      <= {IW{1'b0}};
         out_data_r <= in_data[WIDTH-1:0];
         out_last_r <= in_last && (in_cnt_eff_s == CW'(1));
      end else if (adv_s) begin
         idx_r      <= idx_inc_s;
         out_data_r <= lane_of(data_r, idx_inc_s);
         out_last_r <= last_r && (idx_inc_s == last_idx_s);
      end else if (drain_s) begin
         // Going idle: the last flag must not linger while nothing is shown.
         idx_r      <= {IW{1'b0}};
         out_last_r <= 1'b0;
      end else begin
         // Stalled or idle: everything holds.
         idx_r      <= idx_r;
         out_data_r <= out_data_r;
         out_last_r <= out_last_r;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign in_ready  = in_ready_s;
   assign out_valid = busy_s;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;

endmodule

// File: tb/tb_stream_downsize.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for stream_downsize (WIDTH=8, RATIO=4).
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_stream_downsize;

   localparam int WIDTH = 8;
   localparam int RATIO = 4;
   localparam int CW    = $clog2(RATIO + 1);

   logic                   clk;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH*RATIO-1:0] in_data;
   logic [CW-1:0]          in_cnt;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_data;
   logic                   out_last;

   int n_cmp;
   int n_bad;

   stream_downsize #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_cnt    (in_cnt),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive the input side (no checking here).
   task automatic drive_in(input logic v, input logic [31:0] d,
                           input logic [CW-1:0] c, input logic l);
      in_valid = v;
      in_data  = d;
      in_cnt   = c;
      in_last  = l;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      out_ready = 1'b1;
      drive_in(1'b0, 32'h0, 3'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid cyc %0d: got %b want 0", i, out_valid); end
         n_cmp++;
         if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready cyc %0d: got %b want 1", i, in_ready); end
         n_cmp++;
         if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last cyc %0d: got %b want 0", i, out_last); end
         n_cmp++;
         if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data cyc %0d: got %h want 00", i, out_data); end
      end
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset cyc %0d: got v=%b r=%b l=%b want v=0 r=1 l=0", i, out_valid, in_ready, out_last);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_single_full();
      logic [31:0] w;
      w = 32'hDDCCBBAA;
      out_ready = 1'b1;
      drive_in(1'b1, w, 3'd4, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_accept: in_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== w[k*8 +: 8]) begin
            n_bad++;
            $display("FAIL full_lane %0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, w[k*8 +: 8]);
         end
         n_cmp++;
         if (out_last !== (k == 3)) begin n_bad++; $display("FAIL full_last %0d: got %b want %b", k, out_last, (k == 3)); end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_bad++; $display("FAIL full_idle: got v=%b l=%b want 0 0", out_valid, out_last); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [63:0] both;
      logic [7:0]  exp_d;
      both = 64'h0807060504030201;
      out_ready = 1'b1;
      drive_in(1'b1, both[31:0], 3'd4, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_accept0: in_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      drive_in(1'b1, both[63:32], 3'd4, 1'b1);
      for (int k = 0; k < 8; k++) begin
         exp_d = both[k*8 +: 8];
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== exp_d) begin
            n_bad++;
            $display("FAIL b2b_lane %0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, exp_d);
         end
         n_cmp++;
         if (out_last !== (k == 7)) begin n_bad++; $display("FAIL b2b_last %0d: got %b want %b", k, out_last, (k == 7)); end
         n_cmp++;
         if (in_ready !== (k == 3 || k == 7)) begin
            n_bad++;
            $display("FAIL b2b_in_ready %0d: got %b want %b", k, in_ready, (k == 3 || k == 7));
         end
         @(posedge clk); #1;
         if (k == 3) begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_partial();
      logic [31:0] w;
      out_ready = 1'b1;
      // cnt=2: only the two low lanes, the second carries last.
      w = 32'hFFEE1122;
      drive_in(1'b1, w, 3'd2, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== w[k*8 +: 8] || out_last !== (k == 1)) begin
            n_bad++;
            $display("FAIL cnt2_lane %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, out_valid, out_data, out_last, w[k*8 +: 8], (k == 1));
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL cnt2_no_extra: out_valid got %b (d=%h) want 0", out_valid, out_data); end
      @(posedge clk); #1;

      // cnt=0 and cnt=5 both mean a full word.
      for (int t = 0; t < 2; t++) begin
         w = (t == 0) ? 32'h5A6B7C8D : 32'h13579BDF;
         drive_in(1'b1, w, (t == 0) ? 3'd0 : 3'd5, 1'b1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== w[k*8 +: 8] || out_last !== (k == 3)) begin
               n_bad++;
               $display("FAIL cnt_oor%0d_lane %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", t, k, out_valid, out_data, out_last, w[k*8 +: 8], (k == 3));
            end
            @(posedge clk); #1;
         end
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin n_bad++; $display("FAIL cnt_oor%0d_idle: out_valid got %b want 0", t, out_valid); end
         @(posedge clk); #1;
      end

      // cnt=1: single lane with last, next word taken in the same cycle.
      drive_in(1'b1, 32'hCAFE0033, 3'd1, 1'b1);
      @(posedge clk); #1;
      drive_in(1'b1, 32'h99880077, 3'd1, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h33 || out_last !== 1'b1) begin
         n_bad++;
         $display("FAIL cnt1_first: got v=%b d=%h l=%b want v=1 d=33 l=1", out_valid, out_data, out_last);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL cnt1_in_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h77 || out_last !== 1'b1) begin
         n_bad++;
         $display("FAIL cnt1_second: got v=%b d=%h l=%b want v=1 d=77 l=1", out_valid, out_data, out_last);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL cnt1_idle: out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [31:0] w;
      logic [6:0]  pat;
      int          e;
      w   = 32'hA4A3A2A1;
      pat = 7'b1101001;
      e   = 0;
      out_ready = 1'b1;
      drive_in(1'b1, w, 3'd4, 1'b1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = pat[0];
      for (int j = 0; j < 7; j++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== w[e*8 +: 8] || out_last !== (e == 3)) begin
            n_bad++;
            $display("FAIL bp_lane cyc %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", j, out_valid, out_data, out_last, w[e*8 +: 8], (e == 3));
         end
         n_cmp++;
         if (in_ready !== (pat[j] && e == 3)) begin
            n_bad++;
            $display("FAIL bp_in_ready cyc %0d: got %b want %b", j, in_ready, (pat[j] && e == 3));
         end
         @(posedge clk); #1;
         if (pat[j]) begin
            e++;
         end
         if (j < 6) begin
            out_ready = pat[j+1];
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle: out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_word();
      logic [31:0] w;
      w = 32'hD4C3B2A1;
      out_ready = 1'b1;
      drive_in(1'b1, w, 3'd4, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (out_data !== 8'hB2) begin n_bad++; $display("FAIL rstmid_pre: got %h want b2", out_data); end
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_async: got v=%b d=%h r=%b want v=0 d=00 r=1", out_valid, out_data, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_released: out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
      w = 32'h44332211;
      drive_in(1'b1, w, 3'd4, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== w[k*8 +: 8] || out_last !== (k == 3)) begin
            n_bad++;
            $display("FAIL rstmid_lane %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, out_valid, out_data, out_last, w[k*8 +: 8], (k == 3));
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: out_valid got %b (d=%h) want 0", out_valid, out_data); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_single_full();
      test_back_to_back();
      test_partial();
      test_backpressure();
      test_reset_mid_word();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stream_downsize.md
Name: stream_downsize

Overview:
- Stream width converter. Accepts one wide word of RATIO narrow lanes per valid/ready handshake and emits the lanes one at a time on a narrow valid/ready stream.
- Lane 0 (the LSBs) is emitted first.
- It is the inverse of the team's stream upsizer. It sits between wide internal datapaths and narrow egress interfaces.
- Supports partial final words through a lane count, and preserves packet boundaries through last flags.

Parameters:
WIDTH, 8, width of one narrow lane in bits.
RATIO, 4, number of lanes per wide word; must be 2 or greater.

Ports:
clk  input  1  clock; all logic on its rising edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
in_valid  input  1  wide word offered.
in_ready  output  1  wide word accepted when in_valid && in_ready.
in_data  input  WIDTH*RATIO  wide word; lane k is in_data[k*WIDTH +: WIDTH].
in_cnt  input  $clog2(RATIO+1)  number of valid lanes, counted from lane 0.
in_last  input  1  wide word ends a packet.
out_valid  output  1  narrow lane presented.
out_ready  input  1  consumer accepts when out_valid && out_ready.
out_data  output  WIDTH  current lane.
out_last  output  1  final lane of a packet.

Behaviour:
- Storage:
  - One wide holding register with a latched lane count, a last flag and a lane index.
  - Lane index width is $clog2(RATIO), minimum 1.
- State machine, two states:
  - IDLE: holding register empty.
  - BUSY: holding register holds a word.
- Reset values while rst=0 (asynchronous):
  - State IDLE, lane index 0.
  - out_valid=0, out_last=0, in_ready=1.
  - out_data = 0, since the holding register is cleared.
- Reset mid-operation: the held word is discarded with no partial output. After reset release the block accepts new input on the next edge.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an in handshake: capture in_data, the effective count and in_last. Set index 0 and go to BUSY.
  - out_valid rises on the following cycle, so latency from accept to first lane is 1 cycle.
- Effective count: in_cnt in 1..RATIO is used as given. in_cnt=0 or in_cnt>RATIO is treated as RATIO; no error is flagged.
- BUSY:
  - out_valid=1.
  - out_data = the held lane at the current index.
  - out_last = held_last && (index == cnt-1).
- On an out handshake where index < cnt-1: the index increments. Data and out_valid are stable otherwise.
- On an out handshake where index == cnt-1 (final lane):
  - If in_valid is also high: capture the new word in the same cycle, reset the index to 0 and stay BUSY. There is no bubble.
  - Otherwise: go to IDLE.
- in_ready rule:
  - in_ready = IDLE || (BUSY && index==cnt-1 && out_ready).
  - This is a combinational path from out_ready to in_ready, which is intentional.
- Steady-state throughput: one narrow lane per cycle when the producer keeps in_valid high and out_ready is held high.
- While out_valid=1 and out_ready=0:
  - out_data, out_last and out_valid hold.
  - in_ready=0.
- The input side must keep in_valid, in_data, in_cnt and in_last stable until accepted. The block does not check this.
- Lanes at or above the effective count are never emitted, and their content is ignored.
- A single-lane word (cnt=1) is emitted in one cycle. in_ready is high in that same cycle if out_ready is high.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles, then release -> out_valid=0, in_ready=1, out_last=0 throughout. No output before the first in handshake.
- Single full word: in_data=32'hDDCCBBAA, in_cnt=4, in_last=1, out_ready=1 -> out_data sequence AA, BB, CC, DD on 4 consecutive cycles starting 1 cycle after accept. out_last=1 only with DD. Then idle.
- Back-to-back: words 32'h04030201 then 32'h08070605, in_cnt=4, in_last=0 then 1, in_valid held high, out_ready=1 -> 01..08 on 8 consecutive cycles with no gap. in_ready pulses high only on the cycles emitting 04 and 08 while in_valid is high. out_last only on 08.
- Partial and out-of-range counts:
  - in_cnt=2, in_data=32'hFFEE1122, in_last=1 -> 22 then 11 with last. EE and FF are never emitted.
  - in_cnt=0 -> all 4 lanes emitted.
  - in_cnt=1 -> one lane with last, and the next word is accepted on the same cycle.
- Backpressure: out_ready pattern 1,0,0,1,0,1,1 on one 4-lane word -> each lane holds stable while out_ready=0. Lanes appear in order, none are lost or duplicated, and in_ready=0 throughout the stall.
- Reset mid-word: assert rst=0 after 2 of 4 lanes are emitted -> out_valid falls immediately (asynchronously). After release, a new word 32'h44332211 emits 11, 22, 33, 44 with no remnants of the old word.
